// File: rtl/vga_pkg.sv
// Shared constants for the VGA Wishbone register block: register map, bit indices,
// default field widths and the bus FSM encoding.
package vga_pkg;

    typedef logic [31:0] wb_word_t;

    localparam int unsigned COLOR_W_DEF = 12;
    localparam int unsigned POS_W_DEF   = 10;

    // Byte offsets within the 256-byte decode window.
    localparam logic [7:0] REG_CTRL    = 8'h00;
    localparam logic [7:0] REG_BG      = 8'h04;
    localparam logic [7:0] REG_SPR_POS = 8'h08;
    localparam logic [7:0] REG_SPR_COL = 8'h0C;
    localparam logic [7:0] REG_STATUS  = 8'h10;
    localparam logic [7:0] REG_FCNT    = 8'h14;

    localparam int unsigned CTRL_W      = 2;
    localparam int unsigned CTRL_ENABLE = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;

    localparam int unsigned STATUS_IRQ    = 0;
    localparam int unsigned STATUS_COMMIT = 1;

    localparam logic [0:0] BUS_IDLE = 1'b0;
    localparam logic [0:0] BUS_ACK  = 1'b1;

    function automatic wb_word_t byte_lanes(input logic [3:0] sel);
        wb_word_t mask;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{sel[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/vga_shadow_reg.sv
// One shadowed configuration field: bus writes land in the staging copy, and the active
// copy only follows it when commit is pulsed at a frame boundary.
module vga_shadow_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we,
    input  logic [W-1:0] wmask,
    input  logic [W-1:0] wdata,
    input  logic         commit,
    output logic [W-1:0] stage,
    output logic [W-1:0] active
);

    logic [W-1:0] stage_q, stage_d;
    logic [W-1:0] active_q, active_d;

    // Commit copies the pre-edge staging value, so a colliding write waits a frame.
    always_comb begin
        stage_d = stage_q;
        if (we) begin
            stage_d = (stage_q & ~wmask) | (wdata & wmask);
        end
        active_d = commit ? stage_q : active_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q  <= '0;
            active_q <= '0;
        end else begin
            stage_q  <= stage_d;
            active_q <= active_d;
        end
    end

    assign stage  = stage_q;
    assign active = active_q;

endmodule

// File: rtl/vga_wb_regs.sv
// Wishbone classic slave holding the VGA display configuration, the vblank IRQ and the
// frame counter. Configuration writes are staged and committed at frame start.
module vga_wb_regs
    import vga_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned COLOR_W   = COLOR_W_DEF,
    parameter int unsigned POS_W     = POS_W_DEF
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    input  logic               frame_start_i,
    output logic               enable_o,
    output logic [COLOR_W-1:0] bg_color_o,
    output logic [POS_W-1:0]   spr_x_o,
    output logic [POS_W-1:0]   spr_y_o,
    output logic [COLOR_W-1:0] spr_color_o,
    output logic               irq_o
);

    logic [0:0]   bus_state_q, bus_state_d;
    logic         hit, req, wr, rd;
    logic [7:0]   offset;
    wb_word_t     lanes, rdata;
    wb_word_t     dat_q, dat_d;

    logic         wr_ctrl, wr_bg, wr_pos, wr_col, wr_status, stage_wr;
    logic         commit, irq_set, irq_clr;
    logic         irq_pending_q, irq_pending_d;
    logic         commit_pending_q, commit_pending_d;
    logic [15:0]  frame_cnt_q, frame_cnt_d;

    logic [CTRL_W-1:0]  ctrl_stage, ctrl_active;
    logic [COLOR_W-1:0] bg_stage, bg_active;
    logic [COLOR_W-1:0] col_stage, col_active;
    logic [POS_W-1:0]   x_stage, x_active;
    logic [POS_W-1:0]   y_stage, y_active;
    logic               unused_bits;

    // Bus decode; the FSM being in ACK blocks a second request in the same access.
    assign hit    = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign req    = wbs_cyc_i & wbs_stb_i & hit & (bus_state_q == BUS_IDLE);
    assign wr     = req & wbs_we_i;
    assign rd     = req & ~wbs_we_i;
    assign offset = {wbs_adr_i[7:2], 2'b00};
    assign lanes  = byte_lanes(wbs_sel_i);

    assign wr_ctrl   = wr & (offset == REG_CTRL);
    assign wr_bg     = wr & (offset == REG_BG);
    assign wr_pos    = wr & (offset == REG_SPR_POS);
    assign wr_col    = wr & (offset == REG_SPR_COL);
    assign wr_status = wr & (offset == REG_STATUS);
    assign stage_wr  = wr_ctrl | wr_bg | wr_pos | wr_col;

    assign commit  = frame_start_i & commit_pending_q;
    assign irq_set = frame_start_i & ctrl_active[CTRL_IRQ_EN];
    assign irq_clr = wr_status & wbs_sel_i[0] & wbs_dat_i[STATUS_IRQ];

    vga_shadow_reg #(.W(CTRL_W)) u_ctrl (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_n),
        .we     (wr_ctrl),
        .wmask  (lanes[CTRL_W-1:0]),
        .wdata  (wbs_dat_i[CTRL_W-1:0]),
        .commit (commit),
        .stage  (ctrl_stage),
        .active (ctrl_active)
    );

    vga_shadow_reg #(.W(COLOR_W)) u_bg (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_n),
        .we     (wr_bg),
        .wmask  (lanes[COLOR_W-1:0]),
        .wdata  (wbs_dat_i[COLOR_W-1:0]),
        .commit (commit),
        .stage  (bg_stage),
        .active (bg_active)
    );

    vga_shadow_reg #(.W(POS_W)) u_spr_x (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_n),
        .we     (wr_pos),
        .wmask  (lanes[POS_W-1:0]),
        .wdata  (wbs_dat_i[POS_W-1:0]),
        .commit (commit),
        .stage  (x_stage),
        .active (x_active)
    );

    vga_shadow_reg #(.W(POS_W)) u_spr_y (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_n),
        .we     (wr_pos),
        .wmask  (lanes[16 +: POS_W]),
        .wdata  (wbs_dat_i[16 +: POS_W]),
        .commit (commit),
        .stage  (y_stage),
        .active (y_active)
    );

    vga_shadow_reg #(.W(COLOR_W)) u_spr_col (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_n),
        .we     (wr_col),
        .wmask  (lanes[COLOR_W-1:0]),
        .wdata  (wbs_dat_i[COLOR_W-1:0]),
        .commit (commit),
        .stage  (col_stage),
        .active (col_active)
    );

    // Shadowed registers read back their staging value.
    always_comb begin
        rdata = '0;
        unique case (offset)
            REG_CTRL:    rdata[CTRL_W-1:0]  = ctrl_stage;
            REG_BG:      rdata[COLOR_W-1:0] = bg_stage;
            REG_SPR_POS: begin
                rdata[POS_W-1:0]   = x_stage;
                rdata[16 +: POS_W] = y_stage;
            end
            REG_SPR_COL: rdata[COLOR_W-1:0] = col_stage;
            REG_STATUS: begin
                rdata[STATUS_IRQ]    = irq_pending_q;
                rdata[STATUS_COMMIT] = commit_pending_q;
            end
            REG_FCNT:    rdata[15:0] = frame_cnt_q;
            default:     rdata = '0;
        endcase
    end

    always_comb begin
        bus_state_d   = req ? BUS_ACK : BUS_IDLE;
        dat_d         = rd ? rdata : '0;
        // A same-cycle frame-start set beats a W1C.
        irq_pending_d = irq_set | (irq_pending_q & ~irq_clr);
        commit_pending_d = commit_pending_q;
        if (stage_wr) begin
            commit_pending_d = 1'b1;
        end else if (commit) begin
            commit_pending_d = 1'b0;
        end
        frame_cnt_d = frame_start_i ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            bus_state_q      <= BUS_IDLE;
            dat_q            <= '0;
            irq_pending_q    <= 1'b0;
            commit_pending_q <= 1'b0;
            frame_cnt_q      <= '0;
        end else begin
            bus_state_q      <= bus_state_d;
            dat_q            <= dat_d;
            irq_pending_q    <= irq_pending_d;
            commit_pending_q <= commit_pending_d;
            frame_cnt_q      <= frame_cnt_d;
        end
    end

    assign wbs_ack_o   = (bus_state_q == BUS_ACK);
    assign wbs_dat_o   = dat_q;
    assign enable_o    = ctrl_active[CTRL_ENABLE];
    assign bg_color_o  = bg_active;
    assign spr_x_o     = x_active;
    assign spr_y_o     = y_active;
    assign spr_color_o = col_active;
    assign irq_o       = irq_pending_q & ctrl_active[CTRL_IRQ_EN];

    assign unused_bits = ^{wbs_adr_i, wbs_dat_i, lanes};

endmodule

// File: tb/tb_vga_wb_regs.sv
// Bench for vga_wb_regs: a directed table of bus/frame operations, hand-written corner
// sequences, and randomized traffic compared against a register-map level model.
module tb_vga_wb_regs;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int K_NOP = 0;
    localparam int K_WR  = 1;
    localparam int K_RD  = 2;
    // Writable bits of CTRL, BG_COLOR, SPR_POS, SPR_COLOR as seen on the bus.
    localparam logic [31:0] FMASK [4] = '{32'h0000_0003, 32'h0000_0FFF, 32'h03FF_03FF,
                                          32'h0000_0FFF};

    logic        clk, rst_n, cyc, stb, we, fs;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack, en, irq;
    logic [31:0] rdat;
    logic [11:0] bg, scol;
    logic [9:0]  sx, sy;

    int n_tests = 0;
    int n_fail  = 0;

    vga_wb_regs dut (
        .wb_clk_i      (clk),
        .wb_rst_n      (rst_n),
        .wbs_cyc_i     (cyc),
        .wbs_stb_i     (stb),
        .wbs_we_i      (we),
        .wbs_sel_i     (sel),
        .wbs_adr_i     (adr),
        .wbs_dat_i     (wdat),
        .wbs_ack_o     (ack),
        .wbs_dat_o     (rdat),
        .frame_start_i (fs),
        .enable_o      (en),
        .bg_color_o    (bg),
        .spr_x_o       (sx),
        .spr_y_o       (sy),
        .spr_color_o   (scol),
        .irq_o         (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state (register images in bus layout).
    logic [31:0] m_stage [4];
    logic [31:0] m_active [4];
    logic        m_irq, m_cp, m_ack;
    logic [15:0] m_fcnt;
    logic [31:0] m_dat;

    task automatic model_edge();
        logic [31:0] lm, rv;
        logic        req, commit, set;
        int          idx;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_stage[i]  = '0;
                m_active[i] = '0;
            end
            m_irq = 0; m_cp = 0; m_ack = 0; m_fcnt = '0; m_dat = '0;
            return;
        end
        req = cyc && stb && (adr[31:8] == BASE[31:8]) && !m_ack;
        idx = int'(adr[7:2]);
        rv  = '0;
        if (idx < 4)       rv = m_stage[idx];
        else if (idx == 4) rv = {30'b0, m_cp, m_irq};
        else if (idx == 5) rv = {16'b0, m_fcnt};
        m_dat  = (req && !we) ? rv : '0;
        commit = fs && m_cp;
        set    = fs && m_active[0][1];
        if (commit) begin
            for (int i = 0; i < 4; i++) m_active[i] = m_stage[i];
        end
        if (req && we && idx < 4) begin
            for (int b = 0; b < 4; b++) lm[8*b +: 8] = sel[b] ? 8'hFF : 8'h00;
            lm = lm & FMASK[idx];
            m_stage[idx] = (m_stage[idx] & ~lm) | (wdat & lm);
            m_cp = 1;
        end else if (commit) begin
            m_cp = 0;
        end
        if (req && we && idx == 4 && sel[0] && wdat[0]) m_irq = 0;
        if (set) m_irq = 1;
        if (fs) m_fcnt = m_fcnt + 16'd1;
        m_ack = req;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("mdl_ack", 32'(ack), 32'(m_ack));
        check("mdl_dat", rdat, m_dat);
        check("mdl_en", 32'(en), 32'(m_active[0][0]));
        check("mdl_bg", 32'(bg), m_active[1] & 32'hFFF);
        check("mdl_x", 32'(sx), m_active[2] & 32'h3FF);
        check("mdl_y", 32'(sy), (m_active[2] >> 16) & 32'h3FF);
        check("mdl_col", 32'(scol), m_active[3] & 32'hFFF);
        check("mdl_irq", 32'(irq), 32'(m_irq & m_active[0][1]));
    endtask

    task automatic tick(input bit chk);
        @(posedge clk);
        model_edge();
        #1;
        if (chk) compare_all();
    endtask

    task automatic idle();
        cyc = 0; stb = 0; we = 0; fs = 0;
    endtask

    // One request cycle followed by one idle cycle.
    task automatic do_req(input bit we_v, input logic [31:0] adr_v, input logic [3:0] sel_v,
                          input logic [31:0] dat_v, input bit fs_v,
                          output logic ack_v, output logic [31:0] rd_v);
        cyc = 1; stb = 1; we = we_v; adr = adr_v; sel = sel_v; wdat = dat_v; fs = fs_v;
        tick(1);
        ack_v = ack;
        rd_v  = rdat;
        idle();
        tick(1);
    endtask

    typedef struct {
        int          kind;
        logic [7:0]  off;
        logic [3:0]  sel;
        logic [31:0] dat;
        bit          fs;
        logic [31:0] exp_rd;
        bit          exp_en;
        logic [11:0] exp_bg;
        logic [9:0]  exp_x;
        logic [9:0]  exp_y;
        logic [11:0] exp_col;
        bit          exp_irq;
    } vec_t;

    function automatic vec_t mk(int kind, logic [7:0] off, logic [3:0] s, logic [31:0] d,
                                bit f, logic [31:0] erd, bit een, logic [11:0] ebg,
                                logic [9:0] ex, logic [9:0] ey, logic [11:0] ecol, bit eirq);
        vec_t v;
        v.kind = kind; v.off = off; v.sel = s; v.dat = d; v.fs = f; v.exp_rd = erd;
        v.exp_en = een; v.exp_bg = ebg; v.exp_x = ex; v.exp_y = ey; v.exp_col = ecol;
        v.exp_irq = eirq;
        return v;
    endfunction

    initial begin
        vec_t        vecs [$];
        logic        a;
        logic [31:0] r;

        rst_n = 0; cyc = 0; stb = 0; we = 0; fs = 0; sel = '0; adr = BASE; wdat = '0;

        //                  kind   off    sel    dat           fs rd            en bg      x       y       col     irq
        vecs.push_back(mk(K_RD,  8'h00, 4'hF, 32'h0,         0, 32'h0,         0, 12'h0,  10'h0,  10'h0, 12'h0,  0));
        vecs.push_back(mk(K_RD,  8'h04, 4'hF, 32'h0,         0, 32'h0,         0, 12'h0,  10'h0,  10'h0, 12'h0,  0));
        vecs.push_back(mk(K_RD,  8'h08, 4'hF, 32'h0,         0, 32'h0,         0, 12'h0,  10'h0,  10'h0, 12'h0,  0));
        vecs.push_back(mk(K_RD,  8'h0C, 4'hF, 32'h0,         0, 32'h0,         0, 12'h0,  10'h0,  10'h0, 12'h0,  0));
        vecs.push_back(mk(K_RD,  8'h10, 4'hF, 32'h0,         0, 32'h0,         0, 12'h0,  10'h0,  10'h0, 12'h0,  0));
        vecs.push_back(mk(K_RD,  8'h14, 4'hF, 32'h0,         0, 32'h0,         0, 12'h0,  10'h0,  10'h0, 12'h0,  0));
        vecs.push_back(mk(K_RD,  8'h18, 4'hF, 32'h0,         0, 32'h0,         0, 12'h0,  10'h0,  10'h0, 12'h0,  0));
        vecs.push_back(mk(K_WR,  8'h04, 4'hF, 32'hABC,       0, 32'h0,         0, 12'h0,  10'h0,  10'h0, 12'h0,  0));
        vecs.push_back(mk(K_RD,  8'h10, 4'hF, 32'h0,         0, 32'h2,         0, 12'h0,  10'h0,  10'h0, 12'h0,  0));
        vecs.push_back(mk(K_RD,  8'h04, 4'hF, 32'h0,         0, 32'hABC,       0, 12'h0,  10'h0,  10'h0, 12'h0,  0));
        vecs.push_back(mk(K_NOP, 8'h00, 4'h0, 32'h0,         1, 32'h0,         0, 12'hABC,10'h0,  10'h0, 12'h0,  0));
        vecs.push_back(mk(K_RD,  8'h10, 4'hF, 32'h0,         0, 32'h0,         0, 12'hABC,10'h0,  10'h0, 12'h0,  0));
        vecs.push_back(mk(K_WR,  8'h08, 4'h1, 32'h0123_0045, 0, 32'h0,         0, 12'hABC,10'h0,  10'h0, 12'h0,  0));
        vecs.push_back(mk(K_NOP, 8'h00, 4'h0, 32'h0,         1, 32'h0,         0, 12'hABC,10'h45, 10'h0, 12'h0,  0));
        vecs.push_back(mk(K_RD,  8'h08, 4'hF, 32'h0,         0, 32'h45,        0, 12'hABC,10'h45, 10'h0, 12'h0,  0));
        vecs.push_back(mk(K_WR,  8'h00, 4'hF, 32'h3,         0, 32'h0,         0, 12'hABC,10'h45, 10'h0, 12'h0,  0));
        vecs.push_back(mk(K_NOP, 8'h00, 4'h0, 32'h0,         1, 32'h0,         1, 12'hABC,10'h45, 10'h0, 12'h0,  0));
        vecs.push_back(mk(K_NOP, 8'h00, 4'h0, 32'h0,         1, 32'h0,         1, 12'hABC,10'h45, 10'h0, 12'h0,  1));
        vecs.push_back(mk(K_RD,  8'h14, 4'hF, 32'h0,         0, 32'h4,         1, 12'hABC,10'h45, 10'h0, 12'h0,  1));
        vecs.push_back(mk(K_RD,  8'h10, 4'hF, 32'h0,         0, 32'h1,         1, 12'hABC,10'h45, 10'h0, 12'h0,  1));
        vecs.push_back(mk(K_WR,  8'h10, 4'h1, 32'h1,         0, 32'h0,         1, 12'hABC,10'h45, 10'h0, 12'h0,  0));
        vecs.push_back(mk(K_WR,  8'h10, 4'h1, 32'h1,         1, 32'h0,         1, 12'hABC,10'h45, 10'h0, 12'h0,  1));
        vecs.push_back(mk(K_WR,  8'h0C, 4'hF, 32'h0F0,       0, 32'h0,         1, 12'hABC,10'h45, 10'h0, 12'h0,  1));
        vecs.push_back(mk(K_WR,  8'h0C, 4'hF, 32'hF00,       1, 32'h0,         1, 12'hABC,10'h45, 10'h0, 12'h0F0,1));
        vecs.push_back(mk(K_RD,  8'h10, 4'hF, 32'h0,         0, 32'h3,         1, 12'hABC,10'h45, 10'h0, 12'h0F0,1));
        vecs.push_back(mk(K_NOP, 8'h00, 4'h0, 32'h0,         1, 32'h0,         1, 12'hABC,10'h45, 10'h0, 12'hF00,1));
        vecs.push_back(mk(K_RD,  8'h10, 4'hF, 32'h0,         0, 32'h1,         1, 12'hABC,10'h45, 10'h0, 12'hF00,1));
        vecs.push_back(mk(K_WR,  8'h04, 4'h2, 32'hFFFF_FFFF, 0, 32'h0,         1, 12'hABC,10'h45, 10'h0, 12'hF00,1));
        vecs.push_back(mk(K_RD,  8'h04, 4'hF, 32'h0,         0, 32'hFBC,       1, 12'hABC,10'h45, 10'h0, 12'hF00,1));
        vecs.push_back(mk(K_WR,  8'h00, 4'hF, 32'h1,         0, 32'h0,         1, 12'hABC,10'h45, 10'h0, 12'hF00,1));
        vecs.push_back(mk(K_NOP, 8'h00, 4'h0, 32'h0,         1, 32'h0,         1, 12'hFBC,10'h45, 10'h0, 12'hF00,0));
        vecs.push_back(mk(K_RD,  8'h10, 4'hF, 32'h0,         0, 32'h1,         1, 12'hFBC,10'h45, 10'h0, 12'hF00,0));

        tick(1);
        tick(1);
        rst_n = 1;
        tick(1);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc  = (vecs[i].kind != K_NOP);
            stb  = cyc;
            we   = (vecs[i].kind == K_WR);
            adr  = BASE | {24'b0, vecs[i].off};
            sel  = vecs[i].sel;
            wdat = vecs[i].dat;
            fs   = vecs[i].fs;
            tick(1);
            if (vecs[i].kind != K_NOP) check($sformatf("v%0d_ack", i), 32'(ack), 32'd1);
            if (vecs[i].kind == K_RD) check($sformatf("v%0d_rd", i), rdat, vecs[i].exp_rd);
            check($sformatf("v%0d_en", i), 32'(en), 32'(vecs[i].exp_en));
            check($sformatf("v%0d_bg", i), 32'(bg), 32'(vecs[i].exp_bg));
            check($sformatf("v%0d_x", i), 32'(sx), 32'(vecs[i].exp_x));
            check($sformatf("v%0d_y", i), 32'(sy), 32'(vecs[i].exp_y));
            check($sformatf("v%0d_col", i), 32'(scol), 32'(vecs[i].exp_col));
            check($sformatf("v%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
            idle();
            tick(1);
            check($sformatf("v%0d_ack_drop", i), 32'(ack), 32'd0);
        end

        // Address miss: held request, never acked.
        cyc = 1; stb = 1; we = 0; adr = BASE + 32'h100; sel = 4'hF;
        for (int c = 0; c < 8; c++) begin
            tick(1);
            check("miss_ack", 32'(ack), 32'd0);
        end
        idle();
        tick(1);

        // Abort: strobe raised and dropped between edges.
        cyc = 1; stb = 1; we = 1; adr = BASE | 32'h04; sel = 4'hF; wdat = 32'h123;
        #3;
        idle();
        tick(1);
        check("abort_ack", 32'(ack), 32'd0);
        do_req(0, BASE | 32'h04, 4'hF, 32'h0, 0, a, r);
        check("abort_bg", r, 32'hFBC);
        do_req(0, BASE | 32'h10, 4'hF, 32'h0, 0, a, r);
        check("abort_status", r, 32'h1);

        // Back-to-back: held strobe acks every other cycle.
        cyc = 1; stb = 1; we = 0; adr = BASE | 32'h00; sel = 4'hF;
        for (int c = 0; c < 4; c++) begin
            tick(1);
            check("b2b_ack", 32'(ack), (c % 2 == 0) ? 32'd1 : 32'd0);
        end
        idle();
        tick(1);

        // Reset in flight drops the access.
        cyc = 1; stb = 1; we = 0; adr = BASE | 32'h10; rst_n = 0;
        tick(1);
        check("rst_ack", 32'(ack), 32'd0);
        idle();
        tick(1);
        check("rst_bg", 32'(bg), 32'd0);
        check("rst_en", 32'(en), 32'd0);
        rst_n = 1;
        do_req(0, BASE | 32'h0C, 4'hF, 32'h0, 0, a, r);
        check("rst_rd_ack", 32'(a), 32'd1);
        check("rst_rd_col", r, 32'h0);

        // Randomized traffic against the model.
        for (int c = 0; c < 2500; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            cyc   = ($urandom_range(0, 3) != 0);
            stb   = ($urandom_range(0, 3) != 0);
            we    = 1'($urandom_range(0, 1));
            sel   = 4'($urandom);
            wdat  = $urandom;
            adr   = {($urandom_range(0, 7) == 0) ? 24'h30_0001 : 24'h30_0000, 3'b000,
                     3'($urandom_range(0, 7)), 2'($urandom)};
            fs    = ($urandom_range(0, 7) == 0);
            tick(1);
        end
        rst_n = 1;
        idle();
        tick(1);

        // Frame counter wrap.
        rst_n = 0;
        tick(1);
        tick(1);
        rst_n = 1;
        fs = 1;
        for (int c = 0; c < 65535; c++) tick(0);
        fs = 0;
        tick(1);
        do_req(0, BASE | 32'h14, 4'hF, 32'h0, 0, a, r);
        check("fcnt_max", r, 32'h0000_FFFF);
        fs = 1;
        tick(1);
        fs = 0;
        do_req(0, BASE | 32'h14, 4'hF, 32'h0, 0, a, r);
        check("fcnt_wrap", r, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
